aes_cipher_top: RTL and testbench

//   Iterative AES-128 encryption engine (FIPS-197), one round per clock, on-the-fly key expansion.

---
 rtl/aes_cipher_top.sv | 143 ++++++++++++++
 tb/tb_aes_cipher_top.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/aes_cipher_top.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion; done pulses 10 clocks after ld.
// No backpressure: ld always (re)starts, and text_out holds the last ciphertext until the next completion.
module aes_cipher_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    output logic         done,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic [127:0] text_out
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, BUSY} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d, rk_q, rk_d, out_q, out_d;
    logic         done_q, done_d;
    logic [7:0]   rcon;
    logic [31:0]  rot_sub, w0, w1, w2, w3;
    logic [127:0] rk_nxt, sr, mc, rnd_out;
    logic [7:0]   sb [16];

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [10:0] idx;
        idx = 11'h7ff - {a, 3'b000};
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    always_comb begin
        case (cnt_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord folded into the S-box lane order
    assign rot_sub = {sbox(rk_q[23:16]) ^ rcon, sbox(rk_q[15:8]), sbox(rk_q[7:0]), sbox(rk_q[31:24])};
    assign w0      = rk_q[127:96] ^ rot_sub;
    assign w1      = rk_q[95:64] ^ w0;
    assign w2      = rk_q[63:32] ^ w1;
    assign w3      = rk_q[31:0] ^ w2;
    assign rk_nxt  = {w0, w1, w2, w3};

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(st_q[127 - 8*i -: 8]);
        end
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127 - 8*(4*c + r) -: 8] = sb[4*((c + r) % 4) + r];
            end
        end
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
        end
        rnd_out = ((cnt_q == 4'd10) ? sr : mc) ^ rk_nxt;
    end

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        st_d   = st_q;
        rk_d   = rk_q;
        out_d  = out_q;
        done_d = 1'b0;
        if (fsm_q == BUSY) begin
            st_d  = rnd_out;
            rk_d  = rk_nxt;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd10) begin
                out_d  = rnd_out;
                done_d = 1'b1;
                fsm_d  = IDLE;
                cnt_d  = 4'd0;
            end
        end
        // A load overrides the round in flight but still lets a finishing block report done
        if (ld) begin
            st_d  = text_in ^ key;
            rk_d  = key;
            cnt_d = 4'd1;
            fsm_d = BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= IDLE;
            cnt_q  <= 4'd0;
            st_q   <= '0;
            rk_q   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            rk_q   <= rk_d;
            out_q  <= out_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign text_out = out_q;

endmodule

// File: tb/tb_aes_cipher_top.sv
// Directed bench for aes_cipher_top using FIPS-197 vectors, restart and mid-operation reset.
module tb_aes_cipher_top;

    logic         clk;
    logic         rst;
    logic         ld;
    logic         done;
    logic [127:0] key;
    logic [127:0] text_in;
    logic [127:0] text_out;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K3 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_cipher_top dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .done     (done),
        .key      (key),
        .text_in  (text_in),
        .text_out (text_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_watch(input int cycles, input string tag);
        int dn;
        dn = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (done) dn++;
        end
        chk(tag, 128'(dn), 128'd0);
    endtask

    // Launch one block, then check latency, pulse width, result and that text_out held prev while busy
    task automatic run(input logic [127:0] k, input logic [127:0] p, input logic [127:0] exp_ct,
                       input logic [127:0] prev, input string tag);
        int n;
        int holdbad;
        ld      = 1'b1;
        key     = k;
        text_in = p;
        step();
        ld      = 1'b0;
        key     = {$urandom(), $urandom(), $urandom(), $urandom()};
        text_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        n       = 0;
        holdbad = 0;
        do begin
            step();
            n++;
            if (!done && text_out !== prev) holdbad++;
        end while (!done && n < 20);
        chk({tag, "_latency"}, 128'(n), 128'd10);
        chk({tag, "_ct"}, text_out, exp_ct);
        chk({tag, "_hold"}, 128'(holdbad), 128'd0);
        step();
        chk({tag, "_done_width"}, 128'(done), 128'd0);
        chk({tag, "_ct_held"}, text_out, exp_ct);
    endtask

    initial begin
        int dn;
        rst     = 1'b1;
        ld      = 1'b0;
        key     = '0;
        text_in = '0;
        #1;
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_text_out", text_out, 128'd0);
        repeat (3) step();
        rst = 1'b0;
        chk("post_reset_done", 128'(done), 128'd0);
        chk("post_reset_text_out", text_out, 128'd0);
        idle_watch(12, "idle_no_done");

        run(K2, P2, C2, 128'd0, "fips_b");
        run(K3, P3, C3, C2, "fips_c1");
        run(128'd0, 128'd0, C0, C3, "zero");
        run(K2, P2, C2, C0, "back_to_back");

        // Restart: abort a C.1 block four cycles in with the App.B vectors
        ld      = 1'b1;
        key     = K3;
        text_in = P3;
        step();
        ld = 1'b0;
        dn = 0;
        repeat (3) begin
            step();
            if (done) dn++;
        end
        chk("restart_early_done", 128'(dn), 128'd0);
        run(K2, P2, C2, C2, "restart");
        idle_watch(12, "restart_single_done");

        // Mid-operation reset, with a load attempt while reset is held
        ld      = 1'b1;
        key     = K2;
        text_in = P2;
        step();
        ld = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        chk("midrst_text_out", text_out, 128'd0);
        chk("midrst_done", 128'(done), 128'd0);
        ld      = 1'b1;
        key     = K3;
        text_in = P3;
        step();
        ld  = 1'b0;
        rst = 1'b0;
        idle_watch(15, "midrst_no_done");
        chk("midrst_text_out_after", text_out, 128'd0);
        run(K2, P2, C2, 128'd0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
